// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
// ---------------
// Shares one single-port memory bus between the instruction-fetch port and
// the data (load/store) port of the core. Each access is one req/ack bus
// transaction. The data port has fixed priority over fetch. A stall request
// is held towards the pipeline controller until every active access has
// completed. The cycle in which the stall request is low is the pipeline
// advance cycle: both completion flags clear at its edge, the read buffers
// keep their values.
//
// Optional feature, macro BUS_TIMEOUT_EN: a wait counter forces completion
// (read data 0, one-cycle bus_err_o pulse) after TIMEOUT_CYCLES wait cycles
// without an ack. Without the macro a wait lasts until ack and bus_err_o is 0.
//
// Ports:
//   clk, rst           system clock, synchronous active-high reset
//   inst_ce_i/addr_i   fetch request and address
//   inst_o             buffered fetched instruction
//   data_ce_i/we_i/sel_i/addr_i/wdata_i   load/store request
//   data_rdata_o       buffered load data
//   stallreq_o         stall request (combinational)
//   bus_req_o/we_o/sel_o/addr_o/wdata_o   registered bus request
//   bus_rdata_i, bus_ack_i                bus response
//   bus_err_o          timeout pulse (optional feature only)
module mem_bus_arbiter #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inst_ce_i,
  input  logic [ADDR_W-1:0] inst_addr_i,
  output logic [DATA_W-1:0] inst_o,
  input  logic              data_ce_i,
  input  logic              data_we_i,
  input  logic [3:0]        data_sel_i,
  input  logic [ADDR_W-1:0] data_addr_i,
  input  logic [DATA_W-1:0] data_wdata_i,
  output logic [DATA_W-1:0] data_rdata_o,
  output logic              stallreq_o,
  output logic              bus_req_o,
  output logic              bus_we_o,
  output logic [3:0]        bus_sel_o,
  output logic [ADDR_W-1:0] bus_addr_o,
  output logic [DATA_W-1:0] bus_wdata_o,
  input  logic [DATA_W-1:0] bus_rdata_i,
  input  logic              bus_ack_i,
  output logic              bus_err_o
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    DATA_WAIT = 2'd1,
    INST_WAIT = 2'd2
  } state_t;

  state_t            state_r, state_s;
  logic              inst_done_r, inst_done_s;
  logic              data_done_r, data_done_s;
  logic [DATA_W-1:0] inst_buf_r, inst_buf_s;
  logic [DATA_W-1:0] data_buf_r, data_buf_s;
  logic              bus_req_r, bus_req_s;
  logic              bus_we_r, bus_we_s;
  logic [3:0]        bus_sel_r, bus_sel_s;
  logic [ADDR_W-1:0] bus_addr_r, bus_addr_s;
  logic [DATA_W-1:0] bus_wdata_r, bus_wdata_s;
  logic              bus_err_r, bus_err_s;

  logic              data_pend_s;
  logic              inst_pend_s;
  logic              timeout_s;
  logic              complete_s;
  logic [DATA_W-1:0] cpl_rdata_s;

  assign data_pend_s = data_ce_i & ~data_done_r;
  assign inst_pend_s = inst_ce_i & ~inst_done_r;
  assign stallreq_o  = data_pend_s | inst_pend_s;

`ifdef BUS_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CNT_W-1:0] wait_cnt_r;

  // Wait-cycle counter: held at zero outside a wait, counts unacked wait cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt_r <= {CNT_W{1'b0}};
    end else if (state_r == IDLE) begin
      wait_cnt_r <= {CNT_W{1'b0}};
    end else if (!bus_ack_i) begin
      wait_cnt_r <= wait_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      wait_cnt_r <= wait_cnt_r;
    end
  end

  // The count lags by one, so the last unacked wait cycle sees TIMEOUT_CYCLES-1.
  assign timeout_s = bus_req_r & ~bus_ack_i & (wait_cnt_r == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_s = 1'b0;
`endif

  // An ack only counts while a request is outstanding; timeouts complete with zero data.
  assign complete_s  = bus_req_r & (bus_ack_i | timeout_s);
  assign cpl_rdata_s = bus_ack_i ? bus_rdata_i : {DATA_W{1'b0}};

  // Next-state, flag, buffer and bus-request logic.
  always_comb begin
    state_s     = state_r;
    inst_done_s = inst_done_r;
    data_done_s = data_done_r;
    inst_buf_s  = inst_buf_r;
    data_buf_s  = data_buf_r;
    bus_req_s   = bus_req_r;
    bus_we_s    = bus_we_r;
    bus_sel_s   = bus_sel_r;
    bus_addr_s  = bus_addr_r;
    bus_wdata_s = bus_wdata_r;
    bus_err_s   = 1'b0;

    // Pipeline advance cycle: release both completion flags.
    if (!stallreq_o) begin
      inst_done_s = 1'b0;
      data_done_s = 1'b0;
    end else begin
      inst_done_s = inst_done_r;
      data_done_s = data_done_r;
    end

    case (state_r)
      IDLE: begin
        if (data_pend_s) begin
          state_s     = DATA_WAIT;
          bus_req_s   = 1'b1;
          bus_we_s    = data_we_i;
          bus_sel_s   = data_sel_i;
          bus_addr_s  = data_addr_i;
          bus_wdata_s = data_wdata_i;
        end else if (inst_pend_s) begin
          state_s    = INST_WAIT;
          bus_req_s  = 1'b1;
          bus_we_s   = 1'b0;
          bus_sel_s  = 4'hF;
          bus_addr_s = inst_addr_i;
        end else begin
          state_s = IDLE;
        end
      end
      DATA_WAIT: begin
        if (complete_s) begin
          // A flushed requester (ce dropped) gets the data but no completion flag.
          data_buf_s  = cpl_rdata_s;
          data_done_s = data_ce_i;
          bus_req_s   = 1'b0;
          bus_err_s   = timeout_s;
          state_s     = IDLE;
        end else begin
          state_s = DATA_WAIT;
        end
      end
      INST_WAIT: begin
        if (complete_s) begin
          inst_buf_s  = cpl_rdata_s;
          inst_done_s = inst_ce_i;
          bus_req_s   = 1'b0;
          bus_err_s   = timeout_s;
          state_s     = IDLE;
        end else begin
          state_s = INST_WAIT;
        end
      end
      default: begin
        state_s   = IDLE;
        bus_req_s = 1'b0;
      end
    endcase
  end

  // State, flag, buffer and bus-output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      inst_done_r <= 1'b0;
      data_done_r <= 1'b0;
      inst_buf_r  <= {DATA_W{1'b0}};
      data_buf_r  <= {DATA_W{1'b0}};
      bus_req_r   <= 1'b0;
      bus_we_r    <= 1'b0;
      bus_sel_r   <= 4'h0;
      bus_addr_r  <= {ADDR_W{1'b0}};
      bus_wdata_r <= {DATA_W{1'b0}};
      bus_err_r   <= 1'b0;
    end else begin
      state_r     <= state_s;
      inst_done_r <= inst_done_s;
      data_done_r <= data_done_s;
      inst_buf_r  <= inst_buf_s;
      data_buf_r  <= data_buf_s;
      bus_req_r   <= bus_req_s;
      bus_we_r    <= bus_we_s;
      bus_sel_r   <= bus_sel_s;
      bus_addr_r  <= bus_addr_s;
      bus_wdata_r <= bus_wdata_s;
      bus_err_r   <= bus_err_s;
    end
  end

  assign inst_o       = inst_buf_r;
  assign data_rdata_o = data_buf_r;
  assign bus_req_o    = bus_req_r;
  assign bus_we_o     = bus_we_r;
  assign bus_sel_o    = bus_sel_r;
  assign bus_addr_o   = bus_addr_r;
  assign bus_wdata_o  = bus_wdata_r;
  assign bus_err_o    = bus_err_r;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter. Expected bus transactions and
// read results are queued when stimulus is driven; a forked bus responder
// pops and checks transactions, the test tasks pop and check read results.
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_ce;
  logic [31:0] inst_addr;
  logic [31:0] inst_o;
  logic        data_ce;
  logic        data_we;
  logic [3:0]  data_sel;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic [31:0] data_rdata;
  logic        stallreq;
  logic        bus_req;
  logic        bus_we;
  logic [3:0]  bus_sel;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ack;
  logic        bus_err;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(255)) dut (
    .clk(clk), .rst(rst),
    .inst_ce_i(inst_ce), .inst_addr_i(inst_addr), .inst_o(inst_o),
    .data_ce_i(data_ce), .data_we_i(data_we), .data_sel_i(data_sel),
    .data_addr_i(data_addr), .data_wdata_i(data_wdata), .data_rdata_o(data_rdata),
    .stallreq_o(stallreq),
    .bus_req_o(bus_req), .bus_we_o(bus_we), .bus_sel_o(bus_sel),
    .bus_addr_o(bus_addr), .bus_wdata_o(bus_wdata),
    .bus_rdata_i(bus_rdata), .bus_ack_i(bus_ack), .bus_err_o(bus_err)
  );

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] wdata;
    logic        chk_wdata;
    logic [31:0] rdata;
    int          delay;
  } txn_t;

  typedef struct {
    logic        is_data;
    logic [31:0] value;
  } res_t;

  txn_t bus_q[$];
  res_t res_q[$];
  int   total = 0;
  int   bad   = 0;

  logic        resp_en     = 1'b1;
  logic        resp_ack    = 1'b0;
  logic [31:0] resp_rdata  = 32'h0;
  logic        force_ack   = 1'b0;
  logic [31:0] force_rdata = 32'h0;

  assign bus_ack   = resp_en ? resp_ack : force_ack;
  assign bus_rdata = resp_en ? resp_rdata : force_rdata;

  // Bus model: checks each request against the queue, holds it, acks after 'delay' cycles.
  task automatic responder();
    txn_t cur;
    logic active   = 1'b0;
    logic spurious = 1'b0;
    int   wcnt     = 0;
    forever begin
      @(negedge clk);
      if (!resp_en) begin
        resp_ack = 1'b0;
        active   = 1'b0;
      end else if (resp_ack) begin
        resp_ack = 1'b0;
        total++;
        if (bus_req !== 1'b0) begin
          bad++;
          $display("FAIL idle_gap: bus_req=%b after ack, required 0", bus_req);
        end
      end else if (bus_req === 1'b1) begin
        if (!active) begin
          active = 1'b1;
          wcnt   = 0;
          if (bus_q.size() == 0) begin
            spurious = 1'b1;
            total++;
            bad++;
            $display("FAIL unexpected_txn: bus_addr=%h, no transaction expected", bus_addr);
          end else begin
            spurious = 1'b0;
            cur = bus_q.pop_front();
          end
        end
        if (spurious) begin
          resp_ack   = 1'b1;
          resp_rdata = 32'h0;
          active     = 1'b0;
        end else begin
          total++;
          if (bus_addr !== cur.addr || bus_we !== cur.we || bus_sel !== cur.sel ||
              (cur.chk_wdata && bus_wdata !== cur.wdata)) begin
            bad++;
            $display("FAIL bus_txn: addr=%h we=%b sel=%h wdata=%h, required addr=%h we=%b sel=%h wdata=%h",
                     bus_addr, bus_we, bus_sel, bus_wdata, cur.addr, cur.we, cur.sel, cur.wdata);
          end
          if (wcnt == cur.delay) begin
            resp_ack   = 1'b1;
            resp_rdata = cur.rdata;
            active     = 1'b0;
          end else begin
            wcnt++;
          end
        end
      end
    end
  endtask

  // Counts stall cycles from the current (just driven) cycle until release.
  task automatic wait_release(output int cycles, output bit timed_out);
    cycles    = 0;
    timed_out = 1'b0;
    #1;
    while (stallreq === 1'b1) begin
      cycles++;
      if (cycles > 50) begin
        timed_out = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic idle_inputs();
    inst_ce    = 1'b0;
    inst_addr  = 32'h0;
    data_ce    = 1'b0;
    data_we    = 1'b0;
    data_sel   = 4'h0;
    data_addr  = 32'h0;
    data_wdata = 32'h0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    repeat (3) @(negedge clk);
    #1;
    total++;
    if ({bus_req, bus_we, bus_sel, bus_err} !== 7'h0) begin
      bad++;
      $display("FAIL reset_bus_ctl: req=%b we=%b sel=%h err=%b, required all 0", bus_req, bus_we, bus_sel, bus_err);
    end
    total++;
    if ({bus_addr, bus_wdata} !== 64'h0) begin
      bad++;
      $display("FAIL reset_bus_data: addr=%h wdata=%h, required 0", bus_addr, bus_wdata);
    end
    total++;
    if ({inst_o, data_rdata} !== 64'h0 || stallreq !== 1'b0) begin
      bad++;
      $display("FAIL reset_buffers: inst_o=%h data_rdata=%h stall=%b, required 0", inst_o, data_rdata, stallreq);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_fetch();
    int cyc;
    bit to;
    res_t r;
    logic [31:0] obs;
    inst_addr = 32'h0000_0010;
    inst_ce   = 1'b1;
    bus_q.push_back('{addr: 32'h10, we: 1'b0, sel: 4'hF, wdata: 32'h0, chk_wdata: 1'b0, rdata: 32'h3401_1100, delay: 0});
    res_q.push_back('{is_data: 1'b0, value: 32'h3401_1100});
    wait_release(cyc, to);
    total++;
    if (to || cyc != 2) begin
      bad++;
      $display("FAIL fetch_stall: cycles=%0d timeout=%0d, required 2", cyc, to);
    end
    while (res_q.size() > 0) begin
      r = res_q.pop_front();
      obs = r.is_data ? data_rdata : inst_o;
      total++;
      if (obs !== r.value) begin
        bad++;
        $display("FAIL fetch_result: port_data=%0d got=%h required=%h", r.is_data, obs, r.value);
      end
    end
    inst_ce = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_both_ports();
    int cyc;
    bit to;
    res_t r;
    logic [31:0] obs;
    data_ce    = 1'b1;
    data_we    = 1'b0;
    data_sel   = 4'hF;
    data_addr  = 32'h0000_0080;
    data_wdata = 32'h0BAD_F00D;
    inst_ce    = 1'b1;
    inst_addr  = 32'h0000_0014;
    bus_q.push_back('{addr: 32'h80, we: 1'b0, sel: 4'hF, wdata: 32'h0BAD_F00D, chk_wdata: 1'b1, rdata: 32'h1111_2222, delay: 0});
    bus_q.push_back('{addr: 32'h14, we: 1'b0, sel: 4'hF, wdata: 32'h0, chk_wdata: 1'b0, rdata: 32'h5555_AAAA, delay: 0});
    res_q.push_back('{is_data: 1'b1, value: 32'h1111_2222});
    res_q.push_back('{is_data: 1'b0, value: 32'h5555_AAAA});
    wait_release(cyc, to);
    total++;
    if (to || cyc != 4) begin
      bad++;
      $display("FAIL both_stall: cycles=%0d timeout=%0d, required 4", cyc, to);
    end
    while (res_q.size() > 0) begin
      r = res_q.pop_front();
      obs = r.is_data ? data_rdata : inst_o;
      total++;
      if (obs !== r.value) begin
        bad++;
        $display("FAIL both_result: port_data=%0d got=%h required=%h", r.is_data, obs, r.value);
      end
    end
    idle_inputs();
    @(negedge clk);
  endtask

  task automatic test_store_wait();
    int cyc;
    bit to;
    data_ce    = 1'b1;
    data_we    = 1'b1;
    data_sel   = 4'b0011;
    data_addr  = 32'h0000_0040;
    data_wdata = 32'hDEAD_BEEF;
    bus_q.push_back('{addr: 32'h40, we: 1'b1, sel: 4'b0011, wdata: 32'hDEAD_BEEF, chk_wdata: 1'b1, rdata: 32'hCAFE_0000, delay: 3});
    wait_release(cyc, to);
    total++;
    if (to || cyc != 5) begin
      bad++;
      $display("FAIL store_wait_stall: cycles=%0d timeout=%0d, required 5", cyc, to);
    end
    idle_inputs();
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int cyc;
    bit to;
    res_t r;
    logic [31:0] obs;
    data_ce    = 1'b1;
    data_we    = 1'b0;
    data_sel   = 4'hF;
    data_addr  = 32'h0000_0100;
    data_wdata = 32'h0;
    bus_q.push_back('{addr: 32'h100, we: 1'b0, sel: 4'hF, wdata: 32'h0, chk_wdata: 1'b1, rdata: 32'hA5A5_0001, delay: 1});
    res_q.push_back('{is_data: 1'b1, value: 32'hA5A5_0001});
    wait_release(cyc, to);
    total++;
    if (to || cyc != 3) begin
      bad++;
      $display("FAIL b2b_first_stall: cycles=%0d timeout=%0d, required 3", cyc, to);
    end
    while (res_q.size() > 0) begin
      r = res_q.pop_front();
      obs = r.is_data ? data_rdata : inst_o;
      total++;
      if (obs !== r.value) begin
        bad++;
        $display("FAIL b2b_result: port_data=%0d got=%h required=%h", r.is_data, obs, r.value);
      end
    end
    // Next request presented in the advance cycle itself, ce held high.
    data_we    = 1'b1;
    data_sel   = 4'b1100;
    data_addr  = 32'h0000_0104;
    data_wdata = 32'h1234_5678;
    bus_q.push_back('{addr: 32'h104, we: 1'b1, sel: 4'b1100, wdata: 32'h1234_5678, chk_wdata: 1'b1, rdata: 32'h0000_5A5A, delay: 0});
    @(negedge clk);
    wait_release(cyc, to);
    total++;
    if (to || cyc != 2) begin
      bad++;
      $display("FAIL b2b_second_stall: cycles=%0d timeout=%0d, required 2", cyc, to);
    end
    idle_inputs();
    @(negedge clk);
  endtask

  task automatic test_flush();
    int cyc;
    bit to;
    int n;
    inst_ce   = 1'b1;
    inst_addr = 32'h0000_0020;
    bus_q.push_back('{addr: 32'h20, we: 1'b0, sel: 4'hF, wdata: 32'h0, chk_wdata: 1'b0, rdata: 32'h7777_0001, delay: 2});
    @(negedge clk);
    total++;
    if (bus_req !== 1'b1) begin
      bad++;
      $display("FAIL flush_launch: bus_req=%b required 1", bus_req);
    end
    inst_ce = 1'b0;
    #1;
    total++;
    if (stallreq !== 1'b0) begin
      bad++;
      $display("FAIL flush_stall: stallreq=%b required 0", stallreq);
    end
    n = 0;
    @(negedge clk);
    while (bus_req === 1'b1 && n < 20) begin
      n++;
      @(negedge clk);
    end
    #1;
    total++;
    if (bus_req !== 1'b0 || inst_o !== 32'h7777_0001) begin
      bad++;
      $display("FAIL flush_buffered: bus_req=%b inst_o=%h, required 0 and 77770001", bus_req, inst_o);
    end
    // Completion must not have been flagged: a renewed fetch launches a new access.
    inst_ce   = 1'b1;
    inst_addr = 32'h0000_0024;
    bus_q.push_back('{addr: 32'h24, we: 1'b0, sel: 4'hF, wdata: 32'h0, chk_wdata: 1'b0, rdata: 32'h7777_0002, delay: 0});
    wait_release(cyc, to);
    total++;
    if (to || cyc != 2 || inst_o !== 32'h7777_0002) begin
      bad++;
      $display("FAIL flush_refetch: cycles=%0d timeout=%0d inst_o=%h, required 2 cycles and 77770002", cyc, to, inst_o);
    end
    idle_inputs();
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int cyc;
    bit to;
    resp_en    = 1'b0;
    force_ack  = 1'b0;
    data_ce    = 1'b1;
    data_we    = 1'b0;
    data_sel   = 4'hF;
    data_addr  = 32'h0000_0044;
    data_wdata = 32'h0;
    @(negedge clk);
    total++;
    if (bus_req !== 1'b1 || bus_addr !== 32'h44) begin
      bad++;
      $display("FAIL rstmid_launch: bus_req=%b addr=%h, required 1 and 44", bus_req, bus_addr);
    end
    rst = 1'b1;
    @(negedge clk);
    rst         = 1'b0;
    data_ce     = 1'b0;
    force_ack   = 1'b1;
    force_rdata = 32'hBAD0_BAD0;
    #1;
    total++;
    if ({bus_req, bus_we, bus_sel, bus_err} !== 7'h0 || {bus_addr, bus_wdata} !== 64'h0) begin
      bad++;
      $display("FAIL rstmid_bus: req=%b we=%b sel=%h err=%b addr=%h wdata=%h, required all 0",
               bus_req, bus_we, bus_sel, bus_err, bus_addr, bus_wdata);
    end
    total++;
    if ({inst_o, data_rdata} !== 64'h0) begin
      bad++;
      $display("FAIL rstmid_buffers: inst_o=%h data_rdata=%h, required 0", inst_o, data_rdata);
    end
    @(negedge clk);
    force_ack = 1'b0;
    #1;
    total++;
    if (data_rdata !== 32'h0 || inst_o !== 32'h0 || bus_req !== 1'b0 || stallreq !== 1'b0) begin
      bad++;
      $display("FAIL rstmid_late_ack: data_rdata=%h inst_o=%h req=%b stall=%b, required 0",
               data_rdata, inst_o, bus_req, stallreq);
    end
    resp_en = 1'b1;
    @(negedge clk);
    inst_ce   = 1'b1;
    inst_addr = 32'h0000_0030;
    bus_q.push_back('{addr: 32'h30, we: 1'b0, sel: 4'hF, wdata: 32'h0, chk_wdata: 1'b0, rdata: 32'h0000_0ACE, delay: 0});
    wait_release(cyc, to);
    total++;
    if (to || cyc != 2 || inst_o !== 32'h0000_0ACE) begin
      bad++;
      $display("FAIL rstmid_recover: cycles=%0d timeout=%0d inst_o=%h, required 2 cycles and 00000ace", cyc, to, inst_o);
    end
    idle_inputs();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    fork
      responder();
    join_none
    test_reset();
    test_fetch();
    test_both_ports();
    test_store_wait();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    repeat (2) @(negedge clk);
    total++;
    if (bus_q.size() != 0) begin
      bad++;
      $display("FAIL txn_drain: %0d expected transactions never issued, required 0", bus_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares one unified single-port memory bus between the core's instruction-fetch port and its data (load/store) port.
- Sits between the CPU top level and external memory. Sequences each access as a req/ack transaction.
- Raises a stall request to the pipeline controller until every active access has completed.
- Data port has fixed priority over instruction fetch.

Parameters:
- ADDR_W, 32, address width of both ports and the bus
- DATA_W, 32, data width
- TIMEOUT_CYCLES, 255, cycles without ack before a forced completion (used only with the optional feature)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- inst_ce_i  in  1  fetch request active
- inst_addr_i  in  ADDR_W  fetch address
- inst_o  out  DATA_W  fetched instruction (buffered)
- data_ce_i  in  1  load/store request active
- data_we_i  in  1  1 = store
- data_sel_i  in  4  byte lane enables
- data_addr_i  in  ADDR_W  data address
- data_wdata_i  in  DATA_W  store data
- data_rdata_o  out  DATA_W  load data (buffered)
- stallreq_o  out  1  stall request to pipeline controller
- bus_req_o  out  1  bus transaction valid
- bus_we_o  out  1  bus write enable
- bus_sel_o  out  4  bus byte enables
- bus_addr_o  out  ADDR_W  bus address
- bus_wdata_o  out  DATA_W  bus write data
- bus_rdata_i  in  DATA_W  bus read data
- bus_ack_i  in  1  transaction complete, rdata valid this cycle
- bus_err_o  out  1  timeout pulse (optional feature only; tied 0 otherwise)

Behaviour:
- FSM states: IDLE, DATA_WAIT, INST_WAIT.
- Completion flags inst_done and data_done, plus registered buffers inst_buf and data_buf.
- Reset (synchronous, any state, including mid-transaction):
  - state = IDLE; flags = 0; buffers = 0.
  - bus_req_o = 0; bus_we_o = 0; bus_sel_o = 0; bus_addr_o = 0; bus_wdata_o = 0; bus_err_o = 0.
  - An in-flight bus ack after reset is ignored.
- stallreq_o (combinational) = (data_ce_i & ~data_done) | (inst_ce_i & ~inst_done).
- inst_o = inst_buf; data_rdata_o = data_buf.
- IDLE:
  - If data_ce_i & ~data_done: go to DATA_WAIT.
  - Else if inst_ce_i & ~inst_done: go to INST_WAIT.
  - Bus outputs are registered on entry to a WAIT state and held stable until ack.
  - Data launch: bus_we/sel/addr/wdata = data inputs.
  - Fetch launch: bus_we = 0, sel = 4'hF, addr = inst_addr_i.
- DATA_WAIT: on bus_ack_i:
  - data_buf <= bus_rdata_i. Stores also capture rdata; the value is don't-care.
  - data_done <= 1; bus_req_o <= 0; go to IDLE.
- INST_WAIT: on bus_ack_i:
  - inst_buf <= bus_rdata_i; inst_done <= 1; bus_req_o <= 0; go to IDLE.
- Ack while bus_req_o = 0 (including in IDLE): ignored.
- Both ports active: data access first, then fetch. Minimum latency for a zero-wait-state bus (ack the cycle after req):
  - single access: 2 stall cycles
  - both ports: 4 stall cycles
- Release:
  - Any cycle with stallreq_o = 0 is the pipeline-advance cycle.
  - At that cycle's edge both done flags clear; buffers hold.
- Requester drops ce mid-transaction (flush): the bus transaction still runs to ack; its result is buffered but not flagged.
- Back-to-back: a new request is not launched in the same cycle as the ack. IDLE always spends 1 cycle.
- Address/data are not re-sampled while in a WAIT state.

Optional Feature:
- Macro BUS_TIMEOUT_EN.
- Defined:
  - 8-bit+ wait counter cleared on launch and incremented each WAIT cycle without ack.
  - On reaching TIMEOUT_CYCLES: complete as if acked with rdata = 0, bus_req_o <= 0, bus_err_o pulses high 1 cycle, state returns to IDLE.
- Undefined: no counter; WAIT holds indefinitely; bus_err_o constant 0.

Test Plan:
- Fetch only, inst_ce=1 addr=0x0000_0010, ack 1 cycle after req with rdata=0x3401_1100:
  - bus_addr=0x10, sel=F, we=0.
  - stallreq high 2 cycles, then inst_o=0x3401_1100 with stallreq=0.
- Simultaneous load addr=0x80 and fetch addr=0x14:
  - data transaction first (bus_addr=0x80), then fetch (0x14).
  - stallreq high 4 cycles; both buffers correct on release.
- Store sel=4'b0011 wdata=0xDEAD_BEEF addr=0x40, ack delayed 3 cycles:
  - bus outputs stable across all wait cycles.
  - stallreq drops only after ack.
- Reset asserted in DATA_WAIT, ack arrives the following cycle:
  - FSM in IDLE, bus_req_o=0, buffers 0.
  - Late ack ignored.
- With BUS_TIMEOUT_EN, TIMEOUT_CYCLES=4, no ack:
  - bus_err_o pulses once after 4 wait cycles; data_rdata_o=0; stall released.
